// File: rtl/rv_fetch_responder.sv
// Instruction-fetch bus responder: serves core fetches from a 1-cycle synchronous SRAM
// with programmable wait states, restart on address change, NOP + o_err for out-of-range.
// Ports: i_clk, i_reset_n (sync, active-low), i_addr/i_cyc -> o_ack/o_instruction/o_err,
//        o_mem_addr/o_mem_re -> i_mem_rdata (SRAM side).
// Option: define FETCH_RESP_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module rv_fetch_responder #(
  parameter int          ADDR_WIDTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [31:0]           i_addr,
  input  logic                  i_cyc,
  output logic                  o_ack,
  output logic [31:0]           o_instruction,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_re,
  input  logic [31:0]           i_mem_rdata
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [3:0]  WS  = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CAPT,
    S_ACK,
    S_PF_WAIT,
    S_PF_READ,
    S_PF_CAPT
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [29:0]           r_laddr;
  logic [ADDR_WIDTH-1:0] r_word;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_instr;
  logic                  r_mem_re;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  // 33-bit compare so the window size cannot overflow
  logic [31:0]           w_off;
  logic                  w_inr;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_busy;
  logic                  w_chg;
  logic                  w_accept;

  assign w_off  = i_addr - BASE_ADDR;
  assign w_inr  = {1'b0, w_off} < (33'd4 << ADDR_WIDTH);
  assign w_word = w_off[ADDR_WIDTH+1:2];
  assign w_busy = (r_state == S_WAIT) || (r_state == S_READ) ||
                  (r_state == S_CAPT);
  assign w_chg  = i_addr[31:2] != r_laddr;

`ifdef FETCH_RESP_PREFETCH_EN
  logic [29:0]           r_pf_addr;
  logic [ADDR_WIDTH-1:0] r_pf_word;
  logic [31:0]           r_pf_data;
  logic                  r_pf_valid;
  logic                  w_pf_match;
  logic                  w_pf_hit;
  logic                  w_pf_st;

  assign w_pf_match = i_addr[31:2] == r_pf_addr;
  assign w_pf_hit   = r_pf_valid && w_pf_match;
  assign w_pf_st    = (r_state == S_PF_WAIT) || (r_state == S_PF_READ) ||
                      (r_state == S_PF_CAPT);
  // a request for the word being prefetched rides along with the prefetch
  assign w_accept = i_cyc && (((r_state == S_IDLE) && !w_pf_hit) ||
                              (w_busy && w_chg) ||
                              (w_pf_st && !w_pf_match));
`else
  assign w_accept = i_cyc && ((r_state == S_IDLE) || (w_busy && w_chg));
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_laddr    <= '0;
      r_word     <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_instr    <= NOP;
      r_mem_re   <= 1'b0;
      r_mem_addr <= '0;
`ifdef FETCH_RESP_PREFETCH_EN
      r_pf_addr  <= '0;
      r_pf_word  <= '0;
      r_pf_data  <= '0;
      r_pf_valid <= 1'b0;
`endif
    end else begin
      r_ack    <= 1'b0;
      r_mem_re <= 1'b0;
      if (w_accept) begin
`ifdef FETCH_RESP_PREFETCH_EN
        r_pf_valid <= 1'b0;
`endif
        r_laddr <= i_addr[31:2];
        if (w_inr) begin
          r_word <= w_word;
          if (WAIT_STATES == 0) begin
            r_state    <= S_READ;
            r_mem_re   <= 1'b1;
            r_mem_addr <= w_word;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= WS;
          end
        end else begin
          r_state <= S_ACK;
          r_ack   <= 1'b1;
          r_err   <= 1'b1;
          r_instr <= NOP;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
`ifdef FETCH_RESP_PREFETCH_EN
            if (i_cyc && w_pf_hit) begin
              r_state    <= S_ACK;
              r_ack      <= 1'b1;
              r_err      <= 1'b0;
              r_instr    <= r_pf_data;
              r_laddr    <= r_pf_addr;
              r_word     <= r_pf_word;
              r_pf_valid <= 1'b0;
            end
`endif
          end
          S_WAIT: begin
            if (!i_cyc) begin
              r_state <= S_IDLE;
            end else if (r_cnt == 4'd1) begin
              r_state    <= S_READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= r_word;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_READ: r_state <= i_cyc ? S_CAPT : S_IDLE;
          S_CAPT: begin
            if (!i_cyc) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              r_err   <= 1'b0;
              r_instr <= i_mem_rdata;
            end
          end
          S_ACK: begin
`ifdef FETCH_RESP_PREFETCH_EN
            if (!r_err && (r_word != '1)) begin
              r_pf_addr <= r_laddr + 30'd1;
              r_pf_word <= r_word + 1'b1;
              if (WAIT_STATES == 0) begin
                r_state    <= S_PF_READ;
                r_mem_re   <= 1'b1;
                r_mem_addr <= r_word + 1'b1;
              end else begin
                r_state <= S_PF_WAIT;
                r_cnt   <= WS;
              end
            end else begin
              r_state <= S_IDLE;
            end
`else
            r_state <= S_IDLE;
`endif
          end
`ifdef FETCH_RESP_PREFETCH_EN
          S_PF_WAIT: begin
            if (r_cnt == 4'd1) begin
              r_state    <= S_PF_READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= r_pf_word;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_PF_READ: r_state <= S_PF_CAPT;
          S_PF_CAPT: begin
            if (i_cyc && w_pf_match) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              r_err   <= 1'b0;
              r_instr <= i_mem_rdata;
              r_laddr <= r_pf_addr;
              r_word  <= r_pf_word;
            end else begin
              r_state    <= S_IDLE;
              r_pf_data  <= i_mem_rdata;
              r_pf_valid <= 1'b1;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ack         = r_ack;
  assign o_err         = r_err;
  assign o_instruction = r_instr;
  assign o_mem_re      = r_mem_re;
  assign o_mem_addr    = r_mem_addr;

endmodule
